// File: rtl/spi_ram_responder.sv
// SPI SRAM responder (23LC512-style READ 0x03 / WRITE 0x02) with oversampled SPI inputs and a backdoor read port.
// Defining SPI_RAM_RESPONDER_STATUS_EN adds RDSR (0x05) / WRSR (0x01) and byte mode via the mode register.
module spi_ram_responder #(
   parameter int MEM_ADDR_BITS = 8,
   parameter int ADDR_BYTES    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     spi_clk,
   input  logic                     spi_select,
   input  logic                     spi_mosi,
   output logic                     spi_miso,
   output logic                     spi_miso_oe,
   input  logic [MEM_ADDR_BITS-1:0] dbg_addr,
   output logic [7:0]               dbg_data,
   output logic                     active
);

   localparam int ADDR_BITS = 8 * ADDR_BYTES;
   localparam int CNT_W     = $clog2(ADDR_BITS);
   localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_READ, S_WRITE, S_IGNORE} state_e;
   typedef enum logic [1:0] {C_READ, C_WRITE, C_RDSR, C_WRSR} cmd_e;

   // Synchronizers reset to 0 so a select already held low at reset release produces no falling edge.
   logic sclk_m_q, sclk_s_q, sclk_p_q;
   logic sel_m_q, sel_s_q, sel_p_q;
   logic mosi_m_q, mosi_s_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_m_q <= 1'b0; sclk_s_q <= 1'b0; sclk_p_q <= 1'b0;
         sel_m_q  <= 1'b0; sel_s_q  <= 1'b0; sel_p_q  <= 1'b0;
         mosi_m_q <= 1'b0; mosi_s_q <= 1'b0;
      end else begin
         sclk_m_q <= spi_clk;    sclk_s_q <= sclk_m_q; sclk_p_q <= sclk_s_q;
         sel_m_q  <= spi_select; sel_s_q  <= sel_m_q;  sel_p_q  <= sel_s_q;
         mosi_m_q <= spi_mosi;   mosi_s_q <= mosi_m_q;
      end
   end

   logic sclk_rise, sclk_fall, sel_fall, sel_rise;
   assign sclk_rise = sclk_s_q & ~sclk_p_q;
   assign sclk_fall = ~sclk_s_q & sclk_p_q;
   assign sel_fall  = ~sel_s_q & sel_p_q;
   assign sel_rise  = sel_s_q & ~sel_p_q;

   state_e                   state_q, state_d;
   cmd_e                     cmd_q, cmd_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [6:0]               shin_q, shin_d;
   logic [7:0]               shin_nx;
   logic [MEM_ADDR_BITS-2:0] acc_q, acc_d;
   logic [MEM_ADDR_BITS-1:0] acc_nx;
   logic [MEM_ADDR_BITS-1:0] addr_q, addr_d, addr_inc;
   logic [7:0]               out_q, out_d;
   logic                     miso_q, miso_d;
   logic                     mem_we;
   logic                     seq_mode;
   logic [7:0]               mem_q [MEM_DEPTH];

`ifdef SPI_RAM_RESPONDER_STATUS_EN
   logic [7:0] mode_q, mode_d;

   always_ff @(posedge clk) begin
      if (rst) mode_q <= 8'h40;
      else     mode_q <= mode_d;
   end

   assign seq_mode = (mode_q[7:6] != 2'b00);
`else
   assign seq_mode = 1'b1;
`endif

   assign shin_nx  = {shin_q, mosi_s_q};
   assign acc_nx   = {acc_q, mosi_s_q};
   assign addr_inc = addr_q + MEM_ADDR_BITS'(seq_mode);

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      cnt_d   = cnt_q;
      shin_d  = shin_q;
      acc_d   = acc_q;
      addr_d  = addr_q;
      out_d   = out_q;
      miso_d  = miso_q;
      mem_we  = 1'b0;
`ifdef SPI_RAM_RESPONDER_STATUS_EN
      mode_d  = mode_q;
`endif
      // Deselect takes priority over any bit completing on the same clk.
      if (sel_rise) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (sel_fall) begin
                  state_d = S_CMD;
                  cnt_d   = '0;
                  shin_d  = '0;
                  acc_d   = '0;
               end
            end
            S_CMD: begin
               if (sclk_rise) begin
                  shin_d = shin_nx[6:0];
                  cnt_d  = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(7)) begin
                     cnt_d = '0;
                     case (shin_nx)
                        8'h03: begin cmd_d = C_READ;  state_d = S_ADDR; end
                        8'h02: begin cmd_d = C_WRITE; state_d = S_ADDR; end
`ifdef SPI_RAM_RESPONDER_STATUS_EN
                        8'h05: begin cmd_d = C_RDSR; state_d = S_READ; out_d = mode_q; end
                        8'h01: begin cmd_d = C_WRSR; state_d = S_WRITE; end
`endif
                        default: state_d = S_IGNORE;
                     endcase
                  end
               end
            end
            S_ADDR: begin
               if (sclk_rise) begin
                  acc_d = acc_nx[MEM_ADDR_BITS-2:0];
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                     cnt_d  = '0;
                     addr_d = acc_nx;
                     if (cmd_q == C_READ) begin
                        out_d   = mem_q[acc_nx];
                        state_d = S_READ;
                     end else begin
                        state_d = S_WRITE;
                     end
                  end
               end
            end
            S_READ: begin
               if (sclk_fall) begin
                  miso_d = out_q[7];
                  out_d  = {out_q[6:0], 1'b0};
                  cnt_d  = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(7)) begin
                     cnt_d  = '0;
                     addr_d = addr_inc;
                     out_d  = mem_q[addr_inc];
`ifdef SPI_RAM_RESPONDER_STATUS_EN
                     if (cmd_q == C_RDSR) begin
                        addr_d = addr_q;
                        out_d  = mode_q;
                     end
`endif
                  end
               end
            end
            S_WRITE: begin
               if (sclk_rise) begin
                  shin_d = shin_nx[6:0];
                  cnt_d  = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(7)) begin
                     cnt_d  = '0;
                     mem_we = 1'b1;
                     addr_d = addr_inc;
`ifdef SPI_RAM_RESPONDER_STATUS_EN
                     if (cmd_q == C_WRSR) begin
                        mem_we = 1'b0;
                        addr_d = addr_q;
                        mode_d = shin_nx;
                     end
`endif
                  end
               end
            end
            default: ;
         endcase
      end
      if (state_d != S_READ) miso_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cmd_q   <= C_READ;
         cnt_q   <= '0;
         shin_q  <= '0;
         acc_q   <= '0;
         addr_q  <= '0;
         out_q   <= '0;
         miso_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
         shin_q  <= shin_d;
         acc_q   <= acc_d;
         addr_q  <= addr_d;
         out_q   <= out_d;
         miso_q  <= miso_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[addr_q] <= shin_nx;
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = (state_q == S_READ);
   assign active      = (state_q != S_IDLE) && (state_q != S_IGNORE);
   assign dbg_data    = mem_q[dbg_addr];

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: bit-banged SPI mode-0 master with hand-computed expectations.
module tb_spi_ram_responder;

   localparam int HP = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       spi_clk = 1'b0;
   logic       spi_select = 1'b1;
   logic       spi_mosi = 1'b0;
   logic       spi_miso, spi_miso_oe, active;
   logic [7:0] dbg_addr = 8'h00;
   logic [7:0] dbg_data;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   spi_ram_responder dut (
      .clk         (clk),
      .rst         (rst),
      .spi_clk     (spi_clk),
      .spi_select  (spi_select),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data),
      .active      (active)
   );

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_begin();
      spi_select = 1'b0;
      clk_wait(HP);
   endtask

   task automatic spi_end();
      clk_wait(HP);
      spi_select = 1'b1;
      clk_wait(8);
   endtask

   // Master samples MISO (and OE) at the end of each low phase, just before raising spi_clk.
   task automatic spi_xfer(input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx, output logic [7:0] oe);
      rx = 8'h00;
      oe = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = tx[7-i];
         clk_wait(HP);
         rx = {rx[6:0], spi_miso};
         oe = {oe[6:0], spi_miso_oe};
         spi_clk = 1'b1;
         clk_wait(HP);
         spi_clk = 1'b0;
      end
   endtask

   task automatic peek(input logic [7:0] a, output logic [7:0] d);
      dbg_addr = a;
      clk_wait(1);
      d = dbg_data;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clk_wait(4);
      total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
      total++; if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
      rst = 1'b0;
      clk_wait(4);
      total++; if (active !== 1'b0) begin bad++; $display("FAIL post_reset_active got=%b exp=0", active); end
   endtask

   task automatic test_write();
      logic [7:0] rx, oe, d;
      spi_begin();
      spi_xfer(8'h02, 8, rx, oe);
      total++; if (active !== 1'b1) begin bad++; $display("FAIL write_active got=%b exp=1", active); end
      spi_xfer(8'h00, 8, rx, oe);
      spi_xfer(8'h10, 8, rx, oe);
      spi_xfer(8'hAB, 8, rx, oe);
      spi_xfer(8'hCD, 8, rx, oe);
      spi_end();
      total++; if (active !== 1'b0) begin bad++; $display("FAIL write_idle got=%b exp=0", active); end
      peek(8'h10, d);
      total++; if (d !== 8'hAB) begin bad++; $display("FAIL write_mem10 got=%h exp=ab", d); end
      peek(8'h11, d);
      total++; if (d !== 8'hCD) begin bad++; $display("FAIL write_mem11 got=%h exp=cd", d); end
   endtask

   task automatic test_read();
      logic [7:0] rx0, rx1, oe_c, oe_a1, oe_a2, oe0, oe1;
      spi_begin();
      spi_xfer(8'h03, 8, rx0, oe_c);
      spi_xfer(8'h00, 8, rx0, oe_a1);
      spi_xfer(8'h10, 8, rx0, oe_a2);
      spi_xfer(8'h00, 8, rx0, oe0);
      spi_xfer(8'h00, 8, rx1, oe1);
      spi_end();
      total++; if ((oe_c | oe_a1 | oe_a2) !== 8'h00) begin bad++; $display("FAIL read_oe_hdr got=%h exp=00", oe_c | oe_a1 | oe_a2); end
      total++; if (rx0 !== 8'hAB) begin bad++; $display("FAIL read_byte0 got=%h exp=ab", rx0); end
      total++; if (rx1 !== 8'hCD) begin bad++; $display("FAIL read_byte1 got=%h exp=cd", rx1); end
      total++; if ((oe0 & oe1) !== 8'hFF) begin bad++; $display("FAIL read_oe_data got=%h exp=ff", oe0 & oe1); end
      total++; if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL read_oe_after got=%b exp=0", spi_miso_oe); end
   endtask

   task automatic test_wrap();
      logic [7:0] rx, oe, d;
      spi_begin();
      spi_xfer(8'h02, 8, rx, oe);
      spi_xfer(8'h00, 8, rx, oe);
      spi_xfer(8'hFF, 8, rx, oe);
      spi_xfer(8'h11, 8, rx, oe);
      spi_xfer(8'h22, 8, rx, oe);
      spi_end();
      peek(8'hFF, d);
      total++; if (d !== 8'h11) begin bad++; $display("FAIL wrap_memff got=%h exp=11", d); end
      peek(8'h00, d);
      total++; if (d !== 8'h22) begin bad++; $display("FAIL wrap_mem00 got=%h exp=22", d); end
      spi_begin();
      spi_xfer(8'h02, 8, rx, oe);
      spi_xfer(8'h12, 8, rx, oe);
      spi_xfer(8'h34, 8, rx, oe);
      spi_xfer(8'h5A, 8, rx, oe);
      spi_end();
      peek(8'h34, d);
      total++; if (d !== 8'h5A) begin bad++; $display("FAIL wrap_hi_addr got=%h exp=5a", d); end
   endtask

   task automatic test_abort();
      logic [7:0] rx, oe, d;
      spi_begin();
      spi_xfer(8'h02, 8, rx, oe);
      spi_xfer(8'h00, 8, rx, oe);
      spi_xfer(8'h20, 8, rx, oe);
      spi_xfer(8'h77, 8, rx, oe);
      spi_end();
      spi_begin();
      spi_xfer(8'h02, 8, rx, oe);
      spi_xfer(8'h00, 8, rx, oe);
      spi_xfer(8'h20, 8, rx, oe);
      spi_xfer(8'hFF, 5, rx, oe);
      spi_end();
      peek(8'h20, d);
      total++; if (d !== 8'h77) begin bad++; $display("FAIL abort_mem20 got=%h exp=77", d); end
      spi_begin();
      spi_xfer(8'h03, 8, rx, oe);
      spi_xfer(8'h00, 8, rx, oe);
      spi_xfer(8'h20, 8, rx, oe);
      spi_xfer(8'h00, 8, rx, oe);
      spi_end();
      total++; if (rx !== 8'h77) begin bad++; $display("FAIL abort_next_read got=%h exp=77", rx); end
   endtask

   task automatic test_unknown();
      logic [7:0] rx, oe, oe_acc, d;
      oe_acc = 8'h00;
      spi_begin();
      spi_xfer(8'h9F, 8, rx, oe);
      total++; if (active !== 1'b0) begin bad++; $display("FAIL unk_active got=%b exp=0", active); end
      for (int i = 0; i < 3; i++) begin
         spi_xfer(8'hFF, 8, rx, oe);
         oe_acc = oe_acc | oe;
      end
      total++; if (oe_acc !== 8'h00) begin bad++; $display("FAIL unk_oe got=%h exp=00", oe_acc); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL unk_active_end got=%b exp=0", active); end
      spi_end();
      peek(8'h10, d);
      total++; if (d !== 8'hAB) begin bad++; $display("FAIL unk_mem10 got=%h exp=ab", d); end
      peek(8'hFF, d);
      total++; if (d !== 8'h11) begin bad++; $display("FAIL unk_memff got=%h exp=11", d); end
   endtask

`ifdef SPI_RAM_RESPONDER_STATUS_EN
   task automatic test_status();
      logic [7:0] rx0, rx1, oe, d;
      spi_begin();
      spi_xfer(8'h05, 8, rx0, oe);
      spi_xfer(8'h00, 8, rx0, oe);
      spi_xfer(8'h00, 8, rx1, oe);
      spi_end();
      total++; if (rx0 !== 8'h40) begin bad++; $display("FAIL rdsr_byte0 got=%h exp=40", rx0); end
      total++; if (rx1 !== 8'h40) begin bad++; $display("FAIL rdsr_byte1 got=%h exp=40", rx1); end
      spi_begin();
      spi_xfer(8'h01, 8, rx0, oe);
      spi_xfer(8'h00, 8, rx0, oe);
      spi_end();
      spi_begin();
      spi_xfer(8'h03, 8, rx0, oe);
      spi_xfer(8'h00, 8, rx0, oe);
      spi_xfer(8'h10, 8, rx0, oe);
      spi_xfer(8'h00, 8, rx0, oe);
      spi_xfer(8'h00, 8, rx1, oe);
      spi_end();
      total++; if (rx0 !== 8'hAB) begin bad++; $display("FAIL bytemode_rd0 got=%h exp=ab", rx0); end
      total++; if (rx1 !== 8'hAB) begin bad++; $display("FAIL bytemode_rd1 got=%h exp=ab", rx1); end
      spi_begin();
      spi_xfer(8'h01, 8, rx0, oe);
      spi_xfer(8'h40, 8, rx0, oe);
      spi_end();
      peek(8'h11, d);
      total++; if (d !== 8'hCD) begin bad++; $display("FAIL status_mem11 got=%h exp=cd", d); end
   endtask
`else
   task automatic test_status();
      logic [7:0] rx0, rx1, oe;
      spi_begin();
      spi_xfer(8'h05, 8, rx0, oe);
      total++; if (active !== 1'b0) begin bad++; $display("FAIL rdsr_off_active got=%b exp=0", active); end
      spi_xfer(8'h00, 8, rx0, oe);
      total++; if (oe !== 8'h00) begin bad++; $display("FAIL rdsr_off_oe got=%h exp=00", oe); end
      spi_end();
      spi_begin();
      spi_xfer(8'h01, 8, rx0, oe);
      spi_xfer(8'h00, 8, rx0, oe);
      total++; if (active !== 1'b0) begin bad++; $display("FAIL wrsr_off_active got=%b exp=0", active); end
      spi_end();
      spi_begin();
      spi_xfer(8'h03, 8, rx0, oe);
      spi_xfer(8'h00, 8, rx0, oe);
      spi_xfer(8'h10, 8, rx0, oe);
      spi_xfer(8'h00, 8, rx0, oe);
      spi_xfer(8'h00, 8, rx1, oe);
      spi_end();
      total++; if (rx0 !== 8'hAB) begin bad++; $display("FAIL seq_rd0 got=%h exp=ab", rx0); end
      total++; if (rx1 !== 8'hCD) begin bad++; $display("FAIL seq_rd1 got=%h exp=cd", rx1); end
   endtask
`endif

   task automatic test_reset_mid_read();
      logic [7:0] rx, oe;
      spi_begin();
      spi_xfer(8'h03, 8, rx, oe);
      spi_xfer(8'h00, 8, rx, oe);
      spi_xfer(8'h10, 8, rx, oe);
      spi_xfer(8'h00, 3, rx, oe);
      total++; if (rx[2:0] !== 3'b101) begin bad++; $display("FAIL midrd_bits got=%b exp=101", rx[2:0]); end
      rst = 1'b1;
      clk_wait(2);
      total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL midrd_miso got=%b exp=0", spi_miso); end
      total++; if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL midrd_oe got=%b exp=0", spi_miso_oe); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL midrd_active got=%b exp=0", active); end
      rst = 1'b0;
      clk_wait(4);
      spi_xfer(8'h03, 8, rx, oe);
      spi_xfer(8'h00, 8, rx, oe);
      total++; if (active !== 1'b0) begin bad++; $display("FAIL held_sel_active got=%b exp=0", active); end
      total++; if (oe !== 8'h00) begin bad++; $display("FAIL held_sel_oe got=%h exp=00", oe); end
      spi_end();
      spi_begin();
      spi_xfer(8'h03, 8, rx, oe);
      spi_xfer(8'h00, 8, rx, oe);
      spi_xfer(8'h10, 8, rx, oe);
      spi_xfer(8'h00, 8, rx, oe);
      spi_end();
      total++; if (rx !== 8'hAB) begin bad++; $display("FAIL after_reset_read got=%h exp=ab", rx); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_wrap();
      test_abort();
      test_unknown();
      test_status();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
